// File: rtl/led_pattern_controller.sv
// led_pattern_controller
//
// Drives an LED bank with an animated pattern picked by a 2-bit mode request.
// A free-running prescaler produces a step tick; pattern steps and non-zero mode
// changes happen only on tick edges, while a request for mode 0 (off) is applied
// on the very next clock edge.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous, active-high reset
//   mode         requested pattern: 0 off, 1 blink, 2 chase, 3 bar fill
//   leds         registered LED drive, bit 0 = LEDR[0]
//   active_mode  registered, mode currently displayed
//   mode_ack     registered, one-cycle pulse on the edge a new mode becomes active
//   step_tick    combinational, high during the last cycle of each step interval

module led_pattern_controller #(
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned WIDTH       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] leds,
    output logic [1:0]       active_mode,
    output logic             mode_ack,
    output logic             step_tick
);

    localparam int unsigned CntW  = $clog2(TICK_CYCLES);
    localparam int unsigned StepW = $clog2(WIDTH + 1);

    localparam logic [CntW-1:0]  CntMax    = CntW'(TICK_CYCLES - 1);
    localparam logic [StepW-1:0] ChaseLast = StepW'(WIDTH - 1);
    localparam logic [StepW-1:0] BarLast   = StepW'(WIDTH);

    typedef enum logic [1:0] {
        ModeOff   = 2'd0,
        ModeBlink = 2'd1,
        ModeChase = 2'd2,
        ModeBar   = 2'd3
    } mode_e;

    mode_e             state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [StepW-1:0]  step_q, step_d;
    logic [WIDTH-1:0]  leds_q, leds_d;
    logic              ack_q, ack_d;
    mode_e             req;
    logic [StepW-1:0]  step_nxt;

    // LED image for pattern m at step s.
    function automatic logic [WIDTH-1:0] pattern(input mode_e m, input logic [StepW-1:0] s);
        logic [WIDTH-1:0] p;
        p = '0;
        case (m)
            ModeBlink: p = s[0] ? '0 : '1;
            ModeChase: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    p[i] = (StepW'(i) == s);
                end
            end
            ModeBar: begin
                // s == WIDTH is the blank step that closes the fill cycle.
                for (int i = 0; i < int'(WIDTH); i++) begin
                    p[i] = (StepW'(i) <= s) && (s != BarLast);
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Step index after one advance of pattern m.
    function automatic logic [StepW-1:0] next_step(input mode_e m, input logic [StepW-1:0] s);
        logic [StepW-1:0] n;
        n = '0;
        case (m)
            ModeBlink: n = s[0] ? '0 : StepW'(1);
            ModeChase: n = (s == ChaseLast) ? '0 : s + StepW'(1);
            ModeBar:   n = (s == BarLast) ? '0 : s + StepW'(1);
            default:   n = '0;
        endcase
        return n;
    endfunction

    assign req       = mode_e'(mode);
    assign step_tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d    = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        state_d  = state_q;
        step_d   = step_q;
        leds_d   = leds_q;
        ack_d    = 1'b0;
        step_nxt = next_step(state_q, step_q);

        if (req == ModeOff && state_q != ModeOff) begin
            // Switching off never waits for the tick.
            state_d = ModeOff;
            step_d  = '0;
            leds_d  = '0;
            ack_d   = 1'b1;
        end else if (req != state_q && step_tick) begin
            state_d = req;
            step_d  = '0;
            leds_d  = pattern(req, '0);
            ack_d   = 1'b1;
        end else if (req == state_q && step_tick) begin
            step_d  = step_nxt;
            leds_d  = pattern(state_q, step_nxt);
        end
        // A non-zero request away from a tick is dropped, not latched.
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= ModeOff;
            step_q  <= '0;
            leds_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            step_q  <= step_d;
            leds_q  <= leds_d;
            ack_q   <= ack_d;
        end
    end

    assign leds        = leds_q;
    assign active_mode = state_q;
    assign mode_ack    = ack_q;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Self-checking bench for led_pattern_controller (TICK_CYCLES=4, WIDTH=4).
// A behavioural model tracks the prescaler count, the displayed mode and its
// step index, and derives the LED image arithmetically from the pattern rules.

module tb_led_pattern_controller;

    localparam int T = 4;
    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [1:0]   mode;
    logic [W-1:0] leds;
    logic [1:0]   active_mode;
    logic         mode_ack;
    logic         step_tick;

    led_pattern_controller #(
        .TICK_CYCLES (T),
        .WIDTH       (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .leds        (leds),
        .active_mode (active_mode),
        .mode_ack    (mode_ack),
        .step_tick   (step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_acks = 0;

    // Model state: count during the current cycle, displayed mode, step, ack.
    int m_cnt = 0;
    int m_mode = 0;
    int m_step = 0;
    int m_ack = 0;

    function automatic int period(input int m);
        case (m)
            1: return 2;
            2: return W;
            3: return W + 1;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_leds(input int m, input int s);
        case (m)
            1: return (s % 2 == 0) ? (1 << W) - 1 : 0;
            2: return 1 << s;
            3: return (s < W) ? (1 << (s + 1)) - 1 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        m_cnt  = 0;
        m_mode = 0;
        m_step = 0;
        m_ack  = 0;
    endtask

    // Drive one cycle with request m; called just after a rising edge.
    task automatic cycle(input int m);
        int tick;
        int n_cnt, n_mode, n_step, n_ack;
        mode = 2'(m);
        #1;
        tick = (!rst && m_cnt == T - 1) ? 1 : 0;
        chk("step_tick", int'(step_tick), tick);
        n_cnt  = (m_cnt + 1) % T;
        n_mode = m_mode;
        n_step = m_step;
        n_ack  = 0;
        if (rst) begin
            n_cnt  = 0;
            n_mode = 0;
            n_step = 0;
        end else if (m == 0 && m_mode != 0) begin
            n_mode = 0;
            n_step = 0;
            n_ack  = 1;
        end else if (m != m_mode && tick == 1) begin
            n_mode = m;
            n_step = 0;
            n_ack  = 1;
        end else if (m == m_mode && tick == 1) begin
            n_step = (m_step + 1) % period(m_mode);
        end
        @(posedge clk);
        #1;
        m_cnt  = n_cnt;
        m_mode = n_mode;
        m_step = n_step;
        m_ack  = n_ack;
        chk("leds", int'(leds), exp_leds(m_mode, m_step));
        chk("active_mode", int'(active_mode), m_mode);
        chk("mode_ack", int'(mode_ack), m_ack);
        n_acks += int'(mode_ack);
    endtask

    // Assert reset between edges, check the immediate clear, hold one edge, release.
    task automatic async_reset(input int m);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_leds", int'(leds), 0);
        chk("async_rst_mode", int'(active_mode), 0);
        chk("async_rst_ack", int'(mode_ack), 0);
        mreset();
        cycle(m);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        int bar_seq[5];
        int chase_seq[4];
        bar_seq   = '{3, 7, 15, 0, 1};
        chase_seq = '{2, 4, 8, 1};

        // 1. Reset, then chase.
        rst  = 1'b1;
        mode = 2'd2;
        #1;
        chk("reset_leds", int'(leds), 0);
        chk("reset_mode", int'(active_mode), 0);
        chk("reset_ack", int'(mode_ack), 0);
        mreset();
        cycle(2);
        cycle(2);
        rst = 1'b0;
        repeat (4) cycle(2);
        chk("chase_first_leds", int'(leds), 1);
        chk("chase_first_mode", int'(active_mode), 2);
        chk("chase_first_ack", int'(mode_ack), 1);
        cycle(2);
        chk("chase_ack_drop", int'(mode_ack), 0);
        repeat (3) cycle(2);
        chk("chase_e8", int'(leds), chase_seq[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (4) cycle(2);
            chk("chase_step", int'(leds), chase_seq[k]);
        end

        // 2. Blink from idle.
        cycle(0);
        chk("off_from_chase", int'(leds), 0);
        n_acks = 0;
        repeat (16) cycle(1);
        chk("blink_single_ack", n_acks, 1);

        // 3. Bar fill.
        guard = 0;
        while (m_mode != 3 && guard < 10) begin
            cycle(3);
            guard++;
        end
        chk("bar_reached", m_mode, 3);
        chk("bar_first", int'(leds), 1);
        for (int k = 0; k < 5; k++) begin
            repeat (4) cycle(3);
            chk("bar_step", int'(leds), bar_seq[k]);
        end

        // 4. Immediate off from chase at cnt=1.
        guard = 0;
        while (!(m_mode == 2 && m_cnt == 1) && guard < 20) begin
            cycle(2);
            guard++;
        end
        chk("chase_cnt1_reached", (m_mode == 2 && m_cnt == 1) ? 1 : 0, 1);
        cycle(0);
        chk("off_leds", int'(leds), 0);
        chk("off_mode", int'(active_mode), 0);
        chk("off_ack", int'(mode_ack), 1);
        n_acks = 0;
        repeat (12) cycle(0);
        chk("off_stays", int'(leds), 0);
        chk("off_no_ack", n_acks, 0);

        // 5. Discarded request during blink.
        guard = 0;
        while (!(m_mode == 1 && m_cnt == 0) && guard < 20) begin
            cycle(1);
            guard++;
        end
        chk("blink_cnt0_reached", (m_mode == 1 && m_cnt == 0) ? 1 : 0, 1);
        n_acks = 0;
        cycle(3);
        cycle(3);
        cycle(1);
        cycle(1);
        repeat (8) cycle(1);
        chk("discard_no_ack", n_acks, 0);
        chk("discard_mode", int'(active_mode), 1);

        // 6. Asynchronous reset mid-chase with leds=0100.
        guard = 0;
        while (!(m_mode == 2 && exp_leds(m_mode, m_step) == 4) && guard < 40) begin
            cycle(2);
            guard++;
        end
        chk("chase_0100_reached", int'(leds), 4);
        async_reset(2);
        repeat (2) cycle(2);
        chk("restart_no_tick", int'(step_tick), 0);
        cycle(2);
        chk("restart_tick", int'(step_tick), 1);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 12) mode = 2'($urandom_range(0, 3));
            if (r == 99) async_reset(int'(mode));
            else cycle(int'(mode));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_pattern_controller.md
# led_pattern_controller

Drives the board LED bank with an animated pattern chosen by the 2-bit mode from the push-button mode selector. The block holds a free-running step-tick prescaler and a pattern state machine. It applies requested mode changes only on step-tick boundaries, so animations never glitch mid-step; the one exception is mode 0 (off), which is applied on the next clock edge. It sits between the mode selector and the `LEDR` outputs in the top level.

## Interface
- `TICK_CYCLES`, 25_000_000: clock cycles per pattern step (0.5 s at 50 MHz). Minimum 2.
- `WIDTH`, 8: number of LEDs driven. Minimum 2.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `mode` input 2: requested pattern, already synchronous to `clk`. 0 = off, 1 = blink, 2 = chase, 3 = bar fill.
- `leds` output WIDTH: registered LED drive, bit 0 = LEDR[0].
- `active_mode` output 2: registered; the mode currently being displayed.
- `mode_ack` output 1: registered; one-cycle pulse on the edge a new mode becomes active.
- `step_tick` output 1: combinational; high during the last cycle of each step interval.

## Operation
- **Prescaler**
  - `cnt` counts 0..TICK_CYCLES-1 and wraps to 0.
  - `step_tick` = (`cnt` == TICK_CYCLES-1).
  - `cnt` is never cleared except by reset, including on mode changes.
- **State**
  - `active_mode`.
  - `step` counter, 0..WIDTH, sized with $clog2(WIDTH+1).
  - `leds` register.
- **Mode apply rules**, evaluated every edge:
  - `mode` == 0 and `active_mode` != 0: on the next edge, `active_mode`<=0, `leds`<=0, `step`<=0, `mode_ack`<=1. This does not wait for `step_tick`.
  - `mode` != `active_mode`, `mode` != 0, and `step_tick`=1: `active_mode`<=`mode`, `step`<=0, `leds`<=first pattern of the new mode, `mode_ack`<=1.
  - `mode` != `active_mode`, `mode` != 0, and `step_tick`=0: no change. The request is not latched. Only the value of `mode` at the tick edge matters; a request reverted before the tick is discarded with no ack.
  - `mode` == `active_mode` and `step_tick`=1: advance the pattern one step, `mode_ack`<=0.
  - Otherwise hold, with `mode_ack`<=0.
- **Patterns.** `step` s selects the entry; the first pattern is s=0.
  - Mode 0: all zeros. `step` stays 0.
  - Mode 1 (blink): s even = all ones, s odd = all zeros. `step` toggles between 0 and 1.
  - Mode 2 (chase): one-hot, bit s set. `step` runs 0..WIDTH-1, then wraps to 0.
  - Mode 3 (bar fill): the low s+1 bits are set for s = 0..WIDTH-1; s = WIDTH gives all zeros. `step` then wraps to 0, for a period of WIDTH+1 steps.
- **Reset (asynchronous)**
  - `cnt`=0, `active_mode`=0, `step`=0, `leds`=0, `mode_ack`=0.
  - Takes effect immediately, without a clock edge, including mid-pattern.

## Timing
- After reset release, the first `step_tick` is high in cycle TICK_CYCLES-1. The first tick edge is the TICK_CYCLES-th rising edge.
- After that, ticks repeat every TICK_CYCLES cycles.
- **Latency of a non-zero mode change:**
  - Between 1 and TICK_CYCLES edges.
  - `leds`, `active_mode` and `mode_ack` all update on the same edge.
- **Latency of a change to mode 0:** exactly 1 edge.
- **Simultaneous events:**
  - Mode 0 requested while `step_tick`=1: treated as a mode-0 apply, with a single ack.
  - A non-zero mode change coincident with a tick: applied at that tick.
- `mode_ack` is never high for two consecutive cycles unless two applies occur on consecutive edges, i.e. a non-zero apply at a tick followed immediately by a request for 0.

## Test plan
All scenarios use TICK_CYCLES=4, WIDTH=4.
1. **Reset, then chase.** Hold `rst`=1 with `mode`=2. Expect `leds`=0000 and `active_mode`=0. Release reset. At edge 4 expect `leds`=0001, `active_mode`=2 and a one-cycle `mode_ack`. At edges 8, 12, 16, 20 expect 0010, 0100, 1000, 0001 (wrap-around).
2. **Blink.** From idle with `mode`=1: first tick gives 1111, then 0000, then 1111, one per 4 cycles. `mode_ack` pulses exactly once.
3. **Bar fill.** `mode`=3: successive ticks give 0001, 0011, 0111, 1111, 0000, then 0001.
4. **Immediate off.** In mode 2 at `cnt`=1, set `mode`=0. Next edge: `leds`=0000, `active_mode`=0, `mode_ack`=1. No further `leds` changes at later ticks.
5. **Discarded request.** In blink, set `mode`=3 at `cnt`=0 and back to 1 at `cnt`=2. No `mode_ack`, and blink continues in phase.
6. **Asynchronous reset mid-pattern.** Assert `rst` between clock edges during chase with `leds`=0100. `leds`, `active_mode` and `mode_ack` go to 0 before the next edge, and `cnt` restarts from 0 after release.
